// File: rtl/layer_motion_updater.sv
// layer_motion_updater: per-frame sprite animation engine for the layer header memory.
// On each accepted frameStart it walks all 32 layers. For each populated sprite layer it
// adds the per-frame share of velocity to X/Y, keeping a sub-pixel residual per layer.
// On animation frames it also steps curFrame. Results are written back one 16-bit
// register per cycle.
// Ports:
//   clk, reset (sync, active-low), frameStart (vblank pulse)
//   readLayerIndex / layerHeader     : combinational header read
//   writeLayerIndex, layerRegisterIndex, writeLayerData, writeLayerEn : register write
//   busy (pass in progress), done (one-cycle end-of-pass pulse)
module layer_motion_updater #(
  parameter int unsigned FRAME_RATE = 60,
  parameter int unsigned ANIM_DIV   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frameStart,
  output logic [4:0]   readLayerIndex,
  input  logic [127:0] layerHeader,
  output logic [4:0]   writeLayerIndex,
  output logic [2:0]   layerRegisterIndex,
  output logic [15:0]  writeLayerData,
  output logic         writeLayerEn,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NUM_LAYERS = 32;
  localparam logic [4:0]  LAST_LAYER = 5'(NUM_LAYERS - 1);
  localparam logic [7:0]  ANIM_LAST  = 8'(ANIM_DIV - 1);
  localparam logic [8:0]  DIVISOR    = 9'(FRAME_RATE);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIVX, S_DIVY, S_WRX, S_WRY, S_WRF} state_t;

  state_t state, next_state;

  logic [4:0]  layer;
  logic [15:0] hdr_x, hdr_y, hdr_vy;
  logic [7:0]  hdr_nf, hdr_cf;
  logic        hdr_anim;
  logic [7:0]  anim_cnt;
  logic        anim_step;
  logic [15:0] div_q;
  logic [6:0]  div_r;
  logic        div_neg;
  logic [3:0]  div_cnt;
  logic signed [16:0] disp_x, disp_y;
  logic signed [7:0]  new_rem_x, new_rem_y;
  logic signed [7:0]  rem_x [NUM_LAYERS];
  logic signed [7:0]  rem_y [NUM_LAYERS];

  logic        wr_en_c;
  logic [2:0]  wr_reg_c;
  logic [15:0] wr_data_c;
  logic [4:0]  wr_idx_c;
  logic        busy_c, done_c;

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{layerHeader[47:4], layerHeader[2]};

  assign readLayerIndex = layer;

  // Dividend for the next division: X from the live header in LOAD, Y from the latch otherwise
  logic signed [16:0] n_c;
  logic [15:0]        n_mag_c;
  always_comb begin
    n_c = 17'(rem_x[layer]) + 17'($signed(layerHeader[95:80]));
    if (state == S_DIVX) n_c = 17'(rem_y[layer]) + 17'($signed(hdr_vy));
    n_mag_c = n_c[16] ? 16'(-n_c) : 16'(n_c);
  end

  // One restoring-division step on |n|; the sign is reapplied to both results
  logic [7:0]  shifted_c;
  logic [8:0]  trial_c;
  logic [6:0]  step_r_c;
  logic [15:0] step_q_c;
  logic signed [16:0] q_s_c, step_disp_c;
  logic signed [7:0]  r_s_c, step_rem_c;
  always_comb begin
    shifted_c = {div_r, div_q[15]};
    trial_c   = {1'b0, shifted_c} - DIVISOR;
    if (!trial_c[8]) begin
      step_r_c = 7'(trial_c);
      step_q_c = {div_q[14:0], 1'b1};
    end else begin
      step_r_c = 7'(shifted_c);
      step_q_c = {div_q[14:0], 1'b0};
    end
    q_s_c       = signed'({1'b0, step_q_c});
    r_s_c       = signed'({1'b0, step_r_c});
    step_disp_c = div_neg ? -q_s_c : q_s_c;
    step_rem_c  = div_neg ? -r_s_c : r_s_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (frameStart) next_state = S_LOAD;
      S_LOAD: begin
        if (layerHeader[0] && layerHeader[1]) next_state = S_DIVX;
        else if (layer == LAST_LAYER)         next_state = S_IDLE;
      end
      S_DIVX: if (div_cnt == 4'd15) next_state = S_DIVY;
      S_DIVY: if (div_cnt == 4'd15) next_state = S_WRX;
      S_WRX:  next_state = S_WRY;
      S_WRY:  next_state = S_WRF;
      S_WRF:  next_state = (layer == LAST_LAYER) ? S_IDLE : S_LOAD;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode for the upcoming cycle; registered below
  logic [8:0] cf_inc_c;
  logic [7:0] next_frame_c;
  always_comb begin
    wr_en_c      = 1'b0;
    wr_reg_c     = 3'd0;
    wr_data_c    = 16'd0;
    wr_idx_c     = 5'd0;
    cf_inc_c     = {1'b0, hdr_cf} + 9'd1;
    next_frame_c = (cf_inc_c >= {1'b0, hdr_nf}) ? 8'd0 : 8'(cf_inc_c);
    busy_c       = (next_state != S_IDLE);
    done_c       = (state != S_IDLE) && (next_state == S_IDLE);
    case (next_state)
      S_WRX: begin
        wr_en_c   = 1'b1;
        wr_reg_c  = 3'd3;
        wr_data_c = hdr_x + 16'(disp_x);
        wr_idx_c  = layer;
      end
      S_WRY: begin
        wr_en_c   = 1'b1;
        wr_reg_c  = 3'd4;
        wr_data_c = hdr_y + 16'(disp_y);
        wr_idx_c  = layer;
      end
      S_WRF: begin
        if (hdr_anim && anim_step && (hdr_nf != 8'd0)) begin
          wr_en_c   = 1'b1;
          wr_reg_c  = 3'd7;
          wr_data_c = {next_frame_c, hdr_nf};
          wr_idx_c  = layer;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      writeLayerEn       <= 1'b0;
      layerRegisterIndex <= 3'd0;
      writeLayerData     <= 16'd0;
      writeLayerIndex    <= 5'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      writeLayerEn       <= wr_en_c;
      layerRegisterIndex <= wr_reg_c;
      writeLayerData     <= wr_data_c;
      writeLayerIndex    <= wr_idx_c;
      busy               <= busy_c;
      done               <= done_c;
    end
  end

  // Datapath: header latch, divider, residuals, layer walk, animation counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      layer     <= 5'd0;
      hdr_x     <= 16'd0;
      hdr_y     <= 16'd0;
      hdr_vy    <= 16'd0;
      hdr_nf    <= 8'd0;
      hdr_cf    <= 8'd0;
      hdr_anim  <= 1'b0;
      anim_cnt  <= 8'd0;
      anim_step <= 1'b0;
      div_q     <= 16'd0;
      div_r     <= 7'd0;
      div_neg   <= 1'b0;
      div_cnt   <= 4'd0;
      disp_x    <= 17'sd0;
      disp_y    <= 17'sd0;
      new_rem_x <= 8'sd0;
      new_rem_y <= 8'sd0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        rem_x[i] <= 8'sd0;
        rem_y[i] <= 8'sd0;
      end
    end else begin
      case (state)
        S_IDLE: if (frameStart) begin
          anim_step <= (anim_cnt == ANIM_LAST);
          anim_cnt  <= (anim_cnt == ANIM_LAST) ? 8'd0 : anim_cnt + 8'd1;
        end
        S_LOAD: begin
          hdr_x    <= layerHeader[63:48];
          hdr_y    <= layerHeader[79:64];
          hdr_vy   <= layerHeader[111:96];
          hdr_nf   <= layerHeader[119:112];
          hdr_cf   <= layerHeader[127:120];
          hdr_anim <= layerHeader[3];
          div_q    <= n_mag_c;
          div_r    <= 7'd0;
          div_neg  <= n_c[16];
          div_cnt  <= 4'd0;
          if (!(layerHeader[0] && layerHeader[1])) begin
            rem_x[layer] <= 8'sd0;
            rem_y[layer] <= 8'sd0;
            layer        <= layer + 5'd1;
          end
        end
        S_DIVX: begin
          div_cnt <= div_cnt + 4'd1;
          if (div_cnt == 4'd15) begin
            disp_x    <= step_disp_c;
            new_rem_x <= step_rem_c;
            div_q     <= n_mag_c;
            div_r     <= 7'd0;
            div_neg   <= n_c[16];
          end else begin
            div_q <= step_q_c;
            div_r <= step_r_c;
          end
        end
        S_DIVY: begin
          div_cnt <= div_cnt + 4'd1;
          if (div_cnt == 4'd15) begin
            disp_y    <= step_disp_c;
            new_rem_y <= step_rem_c;
          end else begin
            div_q <= step_q_c;
            div_r <= step_r_c;
          end
        end
        S_WRX: rem_x[layer] <= new_rem_x;
        S_WRY: rem_y[layer] <= new_rem_y;
        S_WRF: layer <= layer + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_motion_updater.sv
// Bench for layer_motion_updater: header memory with write-back, a pass-level reference
// model that schedules every expected output cycle, one compare process, directed literal
// checks for known trajectories, then randomized layer sets.
module tb_layer_motion_updater;

  localparam int FR = 60;
  localparam int AD = 4;

  logic         clk;
  logic         reset;
  logic         frameStart;
  logic [4:0]   readLayerIndex;
  logic [127:0] layerHeader;
  logic [4:0]   writeLayerIndex;
  logic [2:0]   layerRegisterIndex;
  logic [15:0]  writeLayerData;
  logic         writeLayerEn;
  logic         busy;
  logic         done;

  layer_motion_updater #(.FRAME_RATE(FR), .ANIM_DIV(AD)) dut (
    .clk(clk), .reset(reset), .frameStart(frameStart),
    .readLayerIndex(readLayerIndex), .layerHeader(layerHeader),
    .writeLayerIndex(writeLayerIndex), .layerRegisterIndex(layerRegisterIndex),
    .writeLayerData(writeLayerData), .writeLayerEn(writeLayerEn),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Header memory seen by the DUT, and the model's own copy
  logic [127:0] tb_mem    [32];
  logic [127:0] model_mem [32];
  assign layerHeader = tb_mem[readLayerIndex];

  logic         host_we;
  logic [4:0]   host_layer;
  logic [127:0] host_data;

  // Literal-check handoff to the compare process
  logic         lit_valid;
  string        lit_name;
  logic [31:0]  lit_act, lit_exp;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state
  int  m_remx [32];
  int  m_remy [32];
  int  m_anim;
  bit  m_step;
  bit  in_pass;
  int  pos, n_s;
  bit  model_valid = 1'b0;
  bit          s_en    [1200];
  bit          s_rdchk [1200];
  logic [4:0]  s_rd    [1200];
  logic [2:0]  s_reg   [1200];
  logic [15:0] s_data  [1200];

  logic        exp_busy, exp_done, exp_en, exp_rdchk, exp_rst;
  logic [4:0]  exp_rd, exp_layer;
  logic [2:0]  exp_reg;
  logic [15:0] exp_data;

  logic [127:0] h;
  int nx, ny, dx, dy, cf, nf, nxt;

  task automatic push(bit en, bit rdchk, int l, int r, int d);
    s_en[n_s]    = en;
    s_rdchk[n_s] = rdchk;
    s_rd[n_s]    = 5'(l);
    s_reg[n_s]   = 3'(r);
    s_data[n_s]  = 16'(d);
    n_s++;
  endtask

  task automatic set_idle();
    exp_busy = 1'b0; exp_en = 1'b0; exp_rdchk = 1'b1; exp_rd = 5'd0;
    exp_layer = 5'd0; exp_reg = 3'd0; exp_data = 16'd0;
  endtask

  task automatic load_exp(int p);
    exp_busy  = 1'b1;
    exp_en    = s_en[p];
    exp_rdchk = s_rdchk[p];
    exp_rd    = s_rd[p];
    exp_layer = s_rd[p];
    exp_reg   = s_reg[p];
    exp_data  = s_data[p];
  endtask

  // Whole-pass expectation built from the header rules and per-layer cycle costs
  task automatic build_pass();
    n_s = 0;
    for (int l = 0; l < 32; l++) begin
      h = model_mem[l];
      if (!(h[0] && h[1])) begin
        push(1'b0, 1'b1, l, 0, 0);
        m_remx[l] = 0;
        m_remy[l] = 0;
      end else begin
        nx = m_remx[l] + int'($signed(h[95:80]));
        dx = nx / FR;
        m_remx[l] = nx - dx * FR;
        ny = m_remy[l] + int'($signed(h[111:96]));
        dy = ny / FR;
        m_remy[l] = ny - dy * FR;
        for (int c = 0; c < 33; c++) push(1'b0, c == 0, l, 0, 0);
        push(1'b1, 1'b0, l, 3, int'(h[63:48]) + dx);
        push(1'b1, 1'b0, l, 4, int'(h[79:64]) + dy);
        cf = int'(h[127:120]);
        nf = int'(h[119:112]);
        nxt = (cf + 1 >= nf) ? 0 : cf + 1;
        if (h[3] && m_step && nf != 0) push(1'b1, 1'b0, l, 7, nxt * 256 + nf);
        else push(1'b0, 1'b0, l, 0, 0);
      end
    end
  endtask

  // Memory write-back plus reference model, advanced once per clock
  always @(posedge clk) begin
    if (writeLayerEn) tb_mem[writeLayerIndex][16*layerRegisterIndex +: 16] <= writeLayerData;
    if (host_we) begin
      tb_mem[host_layer]    <= host_data;
      model_mem[host_layer] =  host_data;
    end
    if (model_valid && exp_en) model_mem[exp_layer][16*exp_reg +: 16] = exp_data;
    model_valid = 1'b1;
    exp_done = 1'b0;
    exp_rst  = 1'b0;
    if (!reset) begin
      in_pass = 1'b0;
      m_anim  = 0;
      for (int i = 0; i < 32; i++) begin m_remx[i] = 0; m_remy[i] = 0; end
      set_idle();
      exp_rst = 1'b1;
    end else if (in_pass) begin
      pos++;
      if (pos >= n_s) begin
        in_pass = 1'b0;
        set_idle();
        exp_done = 1'b1;
      end else load_exp(pos);
    end else if (frameStart) begin
      m_step = (m_anim == AD - 1);
      m_anim = m_step ? 0 : m_anim + 1;
      build_pass();
      in_pass = 1'b1;
      pos = 0;
      load_exp(0);
    end else set_idle();
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (model_valid) begin
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("done", 32'(done), 32'(exp_done));
      cmp("write_en", 32'(writeLayerEn), 32'(exp_en));
      if (exp_en) begin
        cmp("write_layer", 32'(writeLayerIndex), 32'(exp_layer));
        cmp("write_reg", 32'(layerRegisterIndex), 32'(exp_reg));
        cmp("write_data", 32'(writeLayerData), 32'(exp_data));
      end
      if (exp_rdchk) cmp("read_layer", 32'(readLayerIndex), 32'(exp_rd));
      if (exp_rst) begin
        cmp("rst_write_layer", 32'(writeLayerIndex), 32'd0);
        cmp("rst_write_reg", 32'(layerRegisterIndex), 32'd0);
        cmp("rst_write_data", 32'(writeLayerData), 32'd0);
      end
    end
    if (lit_valid) cmp(lit_name, lit_act, lit_exp);
  end

  function automatic logic [127:0] mk(logic [3:0] fl, logic [15:0] x, logic [15:0] y,
                                      logic [15:0] vx, logic [15:0] vy,
                                      logic [7:0] nfr, logic [7:0] cfr);
    return {cfr, nfr, vy, vx, y, x, 44'd0, fl};
  endfunction

  task automatic lit_check(string nm, logic [31:0] act, logic [31:0] exp);
    @(posedge clk); #1;
    lit_name = nm; lit_act = act; lit_exp = exp; lit_valid = 1'b1;
    @(negedge clk); #1;
    lit_valid = 1'b0;
  endtask

  task automatic set_layer(int l, logic [127:0] d);
    @(negedge clk);
    host_we = 1'b1; host_layer = 5'(l); host_data = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 32; i++) set_layer(i, 128'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One pass; optional extra frameStart and optional reset at a cycle offset into the pass
  task automatic run_pass(input int extra_at, input int rst_at, output int lat);
    int k;
    @(negedge clk); frameStart = 1'b1;
    @(negedge clk); frameStart = 1'b0;
    k = 1;
    while (!done && k < 1300) begin
      frameStart = (k == extra_at);
      reset = !(rst_at > 0 && k == rst_at);
      @(negedge clk);
      k++;
      if (rst_at > 0 && k > rst_at + 2) break;
    end
    frameStart = 1'b0;
    reset = 1'b1;
    lat = k;
    if (rst_at == 0 && k >= 1300) lit_check("pass_done_timeout", 32'(done), 32'd1);
  endtask

  int lat;
  int e2 [4] = '{0, 1, 1, 2};
  int e5 [4] = '{16'h0203, 16'h0203, 16'h0203, 16'h0003};

  initial begin
    reset = 1'b0; frameStart = 1'b0;
    host_we = 1'b0; host_layer = 5'd0; host_data = 128'd0;
    lit_valid = 1'b0; lit_name = ""; lit_act = 0; lit_exp = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Constant velocity 120 px/s at 60 fps: +2 per frame, Y untouched
    clear_all();
    set_layer(0, mk(4'b0011, 16'd100, 16'd55, 16'd120, 16'd0, 8'd0, 8'd0));
    run_pass(0, 0, lat);
    lit_check("s1_latency", 32'(lat), 32'd68);
    lit_check("s1_x_frame1", 32'(tb_mem[0][63:48]), 32'd102);
    lit_check("s1_y_frame1", 32'(tb_mem[0][79:64]), 32'd55);
    run_pass(0, 0, lat);
    lit_check("s1_x_frame2", 32'(tb_mem[0][63:48]), 32'd104);
    run_pass(0, 0, lat);
    lit_check("s1_x_frame3", 32'(tb_mem[0][63:48]), 32'd106);

    // Sub-pixel residual accumulation
    reset_dut();
    set_layer(0, mk(4'b0011, 16'd0, 16'd0, 16'd30, 16'd0, 8'd0, 8'd0));
    for (int i = 0; i < 4; i++) begin
      run_pass(0, 0, lat);
      lit_check("s2_x_residual", 32'(tb_mem[0][63:48]), 32'(e2[i]));
    end

    // Negative velocity truncates toward zero
    reset_dut();
    set_layer(0, mk(4'b0011, 16'd10, 16'd0, 16'hFFA6, 16'd0, 8'd0, 8'd0));
    run_pass(0, 0, lat);
    lit_check("s3_x_frame1", 32'(tb_mem[0][63:48]), 32'd9);
    run_pass(0, 0, lat);
    lit_check("s3_x_frame2", 32'(tb_mem[0][63:48]), 32'd7);

    // 16-bit wrap
    reset_dut();
    set_layer(0, mk(4'b0011, 16'd32767, 16'd0, 16'd60, 16'd0, 8'd0, 8'd0));
    run_pass(0, 0, lat);
    lit_check("s4_x_wrap", 32'(tb_mem[0][63:48]), 32'h8000);

    // Animation step every 4th frame, wrapping curFrame 2 -> 0 with numFrames 3
    reset_dut();
    set_layer(0, mk(4'b1011, 16'd0, 16'd0, 16'd0, 16'd0, 8'd3, 8'd2));
    for (int i = 0; i < 4; i++) begin
      run_pass(0, 0, lat);
      lit_check("s5_anim_reg7", 32'(tb_mem[0][127:112]), 32'(e5[i]));
    end

    // Empty pass timing, text/unpopulated layers, ignored re-pulse, mid-pass reset
    reset_dut();
    clear_all();
    run_pass(0, 0, lat);
    lit_check("s6_empty_latency", 32'(lat), 32'd33);
    set_layer(3, mk(4'b0001, 16'd500, 16'd0, 16'd600, 16'd0, 8'd0, 8'd0));
    set_layer(5, mk(4'b0111, 16'd1000, 16'd0, 16'd300, 16'd0, 8'd0, 8'd0));
    set_layer(7, mk(4'b0010, 16'd7, 16'd0, 16'd600, 16'd0, 8'd0, 8'd0));
    run_pass(10, 0, lat);
    lit_check("s6_text_untouched", 32'(tb_mem[3][63:48]), 32'd500);
    lit_check("s6_empty_untouched", 32'(tb_mem[7][63:48]), 32'd7);
    lit_check("s6_hidden_moves", 32'(tb_mem[5][63:48]), 32'd1005);
    run_pass(0, 20, lat);
    lit_check("s6_after_reset", 32'(tb_mem[5][63:48]), 32'd1005);
    run_pass(0, 0, lat);
    lit_check("s6_next_pass", 32'(tb_mem[5][63:48]), 32'd1010);

    // Randomized layer sets, checked cycle by cycle against the model
    for (int r = 0; r < 4; r++) begin
      reset_dut();
      for (int i = 0; i < 32; i++)
        set_layer(i, mk(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom),
                        8'($urandom_range(0, 5)), 8'($urandom_range(0, 6))));
      for (int p = 0; p < 6; p++) begin
        int ex, rs;
        ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 900)) : 0;
        rs = (p == 5 && r == 1) ? int'($urandom_range(5, 300)) : 0;
        run_pass(ex, rs, lat);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
